// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline (fetch and MEM-stage data ports), the
// shared-memory arbiter and the single-ported unified memory.
// The arbiter connects through the slave modport; whoever drives the
// pipeline requests and the memory responses uses the master modport.
interface mem_port_arbiter_if;

    // Instruction-fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    // MEM-stage data port
    logic        dm_valid;
    logic [5:0]  dm_op;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    // Memory side
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    // Pipeline status
    logic        stall;
    logic        err;

    modport slave (
        input  if_req, if_addr,
        input  dm_valid, dm_op, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_ack,
        output dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output stall, err
    );

    modport master (
        output if_req, if_addr,
        output dm_valid, dm_op, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_ack,
        input  dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  stall, err
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the instruction
// fetch port and the MEM-stage load/store port. One access is in flight at
// a time; data wins over fetch because it belongs to the older instruction.
// Hung accesses are aborted after TIMEOUT wait cycles and flag a sticky err.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_arbiter_if.slave     bus
);

    localparam int          CW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [5:0]  OP_STORE  = 6'd13;
    localparam logic [5:0]  OP_LOAD   = 6'd14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           mem_req_q, mem_req_d;
    logic           mem_we_q, mem_we_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [31:0]    mem_wdata_q, mem_wdata_d;
    logic [31:0]    if_rdata_q, if_rdata_d;
    logic [31:0]    dm_rdata_q, dm_rdata_d;
    logic           if_ack_q, if_ack_d;
    logic           dm_ack_q, dm_ack_d;
    logic           err_q, err_d;

    logic           dm_req;
    logic           dm_req_m;
    logic           if_req_m;

    // A requester keeps its request high during its ack cycle, so the ack
    // masks that port to prevent an immediate duplicate grant.
    assign dm_req   = bus.dm_valid & ((bus.dm_op == OP_STORE) | (bus.dm_op == OP_LOAD));
    assign dm_req_m = dm_req & ~dm_ack_q;
    assign if_req_m = bus.if_req & ~if_ack_q;

    // Next-state logic: grant in IDLE, hold the handshake in WAIT, finish on
    // mem_ready or abort when the wait counter hits its last value.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (dm_req_m) begin
                    state_d     = DM_WAIT;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = (bus.dm_op == OP_STORE);
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                end else if (if_req_m) begin
                    state_d     = IF_WAIT;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                end
            end

            IF_WAIT, DM_WAIT: begin
                if (bus.mem_ready || (cnt_q == CNT_LAST)) begin
                    // Completion and abort share the same wind-down; only the
                    // captured data differs (real read data versus zero).
                    // A store owns no read data, so dm_rdata is left alone.
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == IF_WAIT) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_ready ? bus.mem_rdata : 32'd0;
                    end else begin
                        dm_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = bus.mem_ready ? bus.mem_rdata : 32'd0;
                        end
                    end
                    if (!bus.mem_ready) begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any access without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.err       = err_q;

    // The pipeline freezes while either port has an unacknowledged request.
    assign bus.stall = (dm_req & ~dm_ack_q) | (bus.if_req & ~if_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios for latency,
// priority, wait states, timeout and reset, then randomized transactions
// scored against a transaction-level model of memory contents and timing.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] memArr [8];
    logic [31:0] refMem [8];
    logic [31:0] expDmRdata;
    logic [31:0] expIfRdata;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard bound on total run time.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic [5:0] op, input logic [31:0] da,
                                 input logic [31:0] dw, input logic ir, input logic [31:0] ia);
        bus.dm_valid = dv;
        bus.dm_op    = op;
        bus.dm_addr  = da;
        bus.dm_wdata = dw;
        bus.if_req   = ir;
        bus.if_addr  = ia;
    endtask

    task automatic setMemory(input logic rdy, input logic [31:0] rd);
        bus.mem_ready = rdy;
        bus.mem_rdata = rd;
    endtask

    // One granted access with a random number of wait states; called in the
    // cycle the request (or the previous ack) is presented.
    task automatic serveAccess(input logic isDm, input logic isStore, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic otherPending,
                               input logic otherDone);
        int          d;
        logic [2:0]  idx;
        d   = $urandom_range(0, 4);
        idx = addr[4:2];
        nextCycle();
        if (otherDone) begin
            if (isDm) bus.if_req = 1'b0;
            else      bus.dm_valid = 1'b0;
        end
        checkOutput("rnd_grant_req", bus.mem_req, 1'b1);
        checkOutput("rnd_grant_addr", bus.mem_addr, addr);
        checkOutput("rnd_grant_we", bus.mem_we, isStore);
        if (isStore) checkOutput("rnd_grant_wdata", bus.mem_wdata, wdata);
        for (int k = 0; k < d; k++) begin
            nextCycle();
            checkOutput("rnd_wait_req", bus.mem_req, 1'b1);
            checkOutput("rnd_wait_addr", bus.mem_addr, addr);
        end
        setMemory(1'b1, memArr[bus.mem_addr[4:2]]);
        if (bus.mem_we) memArr[bus.mem_addr[4:2]] = bus.mem_wdata;
        if (isStore)   refMem[idx] = wdata;
        else if (isDm) expDmRdata = refMem[idx];
        else           expIfRdata = refMem[idx];
        nextCycle();
        setMemory(1'b0, 32'($urandom));
        checkOutput("rnd_ack_owner", isDm ? bus.dm_ack : bus.if_ack, 1'b1);
        checkOutput("rnd_ack_other", isDm ? bus.if_ack : bus.dm_ack, 1'b0);
        checkOutput("rnd_ack_req", bus.mem_req, 1'b0);
        checkOutput("rnd_dm_rdata", bus.dm_rdata, expDmRdata);
        checkOutput("rnd_if_rdata", bus.if_rdata, expIfRdata);
        checkOutput("rnd_ack_stall", bus.stall, otherPending);
        checkOutput("rnd_err", bus.err, 1'b0);
    endtask

    // A random mix: data only, fetch only, both together, or a non-memory
    // MEM-stage opcode alongside a fetch.
    task automatic runRandomTransaction();
        int          kind;
        logic        dv, ir, dmReq;
        logic [5:0]  op;
        logic [2:0]  di, fi;
        logic [31:0] da, dw, ia;
        kind = $urandom_range(0, 3);
        di   = 3'($urandom_range(0, 7));
        fi   = 3'($urandom_range(0, 7));
        da   = {27'h80, di, 2'b00};
        ia   = {27'h80, fi, 2'b00};
        dw   = 32'($urandom);
        op   = ($urandom_range(0, 1) == 1) ? 6'd13 : 6'd14;
        dv   = (kind != 1);
        ir   = (kind != 0);
        if (kind == 3) begin
            op = 6'($urandom_range(0, 63));
            if (op == 6'd13 || op == 6'd14) op = 6'd0;
        end
        dmReq = dv && (op == 6'd13 || op == 6'd14);
        applyStimulus(dv, op, da, dw, ir, ia);
        setMemory(1'b0, 32'($urandom));
        #1;
        checkOutput("rnd_req_stall", bus.stall, dmReq | ir);
        if (dmReq) serveAccess(1'b1, op == 6'd13, da, dw, ir, 1'b0);
        if (ir)    serveAccess(1'b0, 1'b0, ia, 32'd0, 1'b0, dmReq);
        nextCycle();
        checkOutput("rnd_no_regrant", bus.mem_req, 1'b0);
        checkOutput("rnd_ack_clear", {bus.if_ack, bus.dm_ack}, 2'b00);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        setMemory(1'b0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            memArr[i] = 32'($urandom);
            refMem[i] = memArr[i];
        end

        // Reset values
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst_mem_req", bus.mem_req, 1'b0);
        checkOutput("rst_mem_we", bus.mem_we, 1'b0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
        checkOutput("rst_if_rdata", bus.if_rdata, 32'd0);
        checkOutput("rst_dm_rdata", bus.dm_rdata, 32'd0);
        checkOutput("rst_acks", {bus.if_ack, bus.dm_ack}, 2'b00);
        checkOutput("rst_err", bus.err, 1'b0);
        checkOutput("rst_stall", bus.stall, 1'b0);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Load with mem_ready high from cycle 1
        applyStimulus(1'b1, 6'd14, 32'h40, 32'd0, 1'b0, 32'd0);
        setMemory(1'b1, 32'h1234_5678);
        #1;
        checkOutput("ld_c0_stall", bus.stall, 1'b1);
        nextCycle();
        checkOutput("ld_c1_req", bus.mem_req, 1'b1);
        checkOutput("ld_c1_we", bus.mem_we, 1'b0);
        checkOutput("ld_c1_addr", bus.mem_addr, 32'h40);
        checkOutput("ld_c1_stall", bus.stall, 1'b1);
        nextCycle();
        checkOutput("ld_c2_ack", bus.dm_ack, 1'b1);
        checkOutput("ld_c2_rdata", bus.dm_rdata, 32'h1234_5678);
        checkOutput("ld_c2_req", bus.mem_req, 1'b0);
        checkOutput("ld_c2_stall", bus.stall, 1'b0);
        nextCycle();
        checkOutput("ld_c3_ack", bus.dm_ack, 1'b0);
        checkOutput("ld_c3_req", bus.mem_req, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        setMemory(1'b0, 32'd0);

        // Store keeps dm_rdata
        applyStimulus(1'b1, 6'd13, 32'h80, 32'hCAFE_F00D, 1'b0, 32'd0);
        nextCycle();
        checkOutput("st_req", bus.mem_req, 1'b1);
        checkOutput("st_we", bus.mem_we, 1'b1);
        checkOutput("st_addr", bus.mem_addr, 32'h80);
        checkOutput("st_wdata", bus.mem_wdata, 32'hCAFE_F00D);
        setMemory(1'b1, 32'hDEAD_BEEF);
        nextCycle();
        checkOutput("st_ack", bus.dm_ack, 1'b1);
        checkOutput("st_rdata_kept", bus.dm_rdata, 32'h1234_5678);
        checkOutput("st_done_req", bus.mem_req, 1'b0);
        checkOutput("st_done_we", bus.mem_we, 1'b0);
        setMemory(1'b0, 32'd0);
        nextCycle();
        checkOutput("st_ack_once", bus.dm_ack, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Simultaneous requests: data first, then fetch
        applyStimulus(1'b1, 6'd14, 32'h100, 32'd0, 1'b1, 32'h200);
        setMemory(1'b1, 32'hAAAA_0001);
        #1;
        checkOutput("both_c0_stall", bus.stall, 1'b1);
        nextCycle();
        checkOutput("both_c1_req", bus.mem_req, 1'b1);
        checkOutput("both_c1_addr", bus.mem_addr, 32'h100);
        nextCycle();
        checkOutput("both_c2_dmack", bus.dm_ack, 1'b1);
        checkOutput("both_c2_dmrdata", bus.dm_rdata, 32'hAAAA_0001);
        checkOutput("both_c2_ifack", bus.if_ack, 1'b0);
        checkOutput("both_c2_stall", bus.stall, 1'b1);
        setMemory(1'b1, 32'hBBBB_0002);
        nextCycle();
        checkOutput("both_c3_req", bus.mem_req, 1'b1);
        checkOutput("both_c3_addr", bus.mem_addr, 32'h200);
        checkOutput("both_c3_dmack", bus.dm_ack, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 32'h200);
        nextCycle();
        checkOutput("both_c4_ifack", bus.if_ack, 1'b1);
        checkOutput("both_c4_ifrdata", bus.if_rdata, 32'hBBBB_0002);
        checkOutput("both_c4_stall", bus.stall, 1'b0);
        setMemory(1'b0, 32'd0);
        nextCycle();
        checkOutput("both_c5_ifack", bus.if_ack, 1'b0);
        checkOutput("both_c5_req", bus.mem_req, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Fetch with three wait cycles
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 32'h300);
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            checkOutput("fw_hold_req", bus.mem_req, 1'b1);
            checkOutput("fw_hold_addr", bus.mem_addr, 32'h300);
            checkOutput("fw_hold_ack", bus.if_ack, 1'b0);
        end
        setMemory(1'b1, 32'h1357_9BDF);
        nextCycle();
        checkOutput("fw_ack", bus.if_ack, 1'b1);
        checkOutput("fw_rdata", bus.if_rdata, 32'h1357_9BDF);
        checkOutput("fw_ack_req", bus.mem_req, 1'b0);
        setMemory(1'b0, 32'd0);
        nextCycle();
        checkOutput("fw_no_regrant", bus.mem_req, 1'b0);
        checkOutput("fw_ack_once", bus.if_ack, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Timeout on a load with mem_ready tied low
        applyStimulus(1'b1, 6'd14, 32'h400, 32'd0, 1'b0, 32'd0);
        for (int c = 1; c <= TIMEOUT; c++) begin
            nextCycle();
            checkOutput("to_wait_req", bus.mem_req, 1'b1);
            checkOutput("to_wait_ack", bus.dm_ack, 1'b0);
            checkOutput("to_wait_err", bus.err, 1'b0);
        end
        nextCycle();
        checkOutput("to_abort_req", bus.mem_req, 1'b0);
        checkOutput("to_abort_ack", bus.dm_ack, 1'b1);
        checkOutput("to_abort_rdata", bus.dm_rdata, 32'd0);
        checkOutput("to_abort_err", bus.err, 1'b1);
        nextCycle();
        checkOutput("to_ack_once", bus.dm_ack, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 32'h500);
        setMemory(1'b1, 32'h2468_ACE0);
        nextCycle();
        checkOutput("to_next_addr", bus.mem_addr, 32'h500);
        nextCycle();
        checkOutput("to_next_ack", bus.if_ack, 1'b1);
        checkOutput("to_next_rdata", bus.if_rdata, 32'h2468_ACE0);
        checkOutput("to_err_sticky", bus.err, 1'b1);
        setMemory(1'b0, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Reset in the middle of a wait
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 32'h600);
        nextCycle();
        checkOutput("mr_req_c1", bus.mem_req, 1'b1);
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("mr_req_drop", bus.mem_req, 1'b0);
        checkOutput("mr_acks", {bus.if_ack, bus.dm_ack}, 2'b00);
        checkOutput("mr_err", bus.err, 1'b0);
        checkOutput("mr_if_rdata", bus.if_rdata, 32'd0);
        nextCycle();
        checkOutput("mr_in_reset", bus.mem_req, 1'b0);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("mr_regrant_req", bus.mem_req, 1'b1);
        checkOutput("mr_regrant_addr", bus.mem_addr, 32'h600);
        checkOutput("mr_no_ack", bus.if_ack, 1'b0);
        setMemory(1'b1, 32'h0F0F_0F0F);
        nextCycle();
        checkOutput("mr_ack", bus.if_ack, 1'b1);
        checkOutput("mr_rdata", bus.if_rdata, 32'h0F0F_0F0F);
        setMemory(1'b0, 32'd0);
        nextCycle();
        checkOutput("mr_ack_once", bus.if_ack, 1'b0);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Randomized transactions against the memory model
        expDmRdata = 32'd0;
        expIfRdata = 32'h0F0F_0F0F;
        repeat (150) runRandomTransaction();
        checkOutput("final_err", bus.err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing one single-ported unified memory between the instruction-fetch (IF) port and the data (MEM-stage load/store) port of the 5-stage pipeline. It decodes the MEM-stage opcode, grants one port at a time, holds the memory handshake until the memory answers, and returns read data with a one-cycle acknowledge. It raises `stall` to freeze the pipeline while any access is outstanding, and it aborts hung accesses with a timeout and a sticky error.

## Interface
Parameters:
- `TIMEOUT`, 16 — maximum cycles a granted access waits for `mem_ready` before it is aborted (≥2).

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `if_req` in 1 — fetch request; held high until `if_ack`.
- `if_addr` in 32 — fetch address; stable while `if_req` is high.
- `if_rdata` out 32 — fetched instruction (registered).
- `if_ack` out 1 — one-cycle pulse: fetch complete.
- `dm_valid` in 1 — MEM-stage instruction valid.
- `dm_op` in 6 — MEM-stage opcode `[31:26]`; 13 = store, 14 = load, any other value = no data access.
- `dm_addr` in 32 — data address.
- `dm_wdata` in 32 — store data.
- `dm_rdata` out 32 — load data (registered).
- `dm_ack` out 1 — one-cycle pulse: data access complete.
- `mem_req` out 1 — memory request; registered.
- `mem_we` out 1 — memory write enable; registered.
- `mem_addr` out 32 — memory address; registered.
- `mem_wdata` out 32 — memory write data; registered.
- `mem_rdata` in 32 — memory read data; valid when `mem_ready` is high.
- `mem_ready` in 1 — memory completes the current access in this cycle.
- `stall` out 1 — pipeline freeze; combinational.
- `err` out 1 — sticky timeout flag.

## Operation
- Internal request `dm_req = dm_valid & (dm_op==13 | dm_op==14)`.
- Masking: in a cycle where a port's ack is high, that port's request is ignored, because the requester still holds its request during the ack cycle.
- FSM states: IDLE, IF_WAIT, DM_WAIT.
- **IDLE**
  - If the masked `dm_req` is high, go to DM_WAIT and register `mem_req=1`, `mem_addr=dm_addr`, `mem_we=(dm_op==13)`, `mem_wdata=dm_wdata`.
  - Otherwise, if the masked `if_req` is high, go to IF_WAIT and register `mem_req=1`, `mem_addr=if_addr`, `mem_we=0`.
  - Data has fixed priority over fetch because it belongs to the older instruction.
- **IF_WAIT / DM_WAIT**
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable.
  - On `mem_ready=1`:
    - Clear `mem_req` and `mem_we`.
    - For a fetch, capture `mem_rdata` into `if_rdata`; for a load, into `dm_rdata`. A store leaves `dm_rdata` unchanged.
    - Pulse the owner's ack in the next cycle and return to IDLE.
- **Timeout**
  - A counter clears on grant and increments each WAIT cycle without `mem_ready`.
  - If it reaches `TIMEOUT-1` with `mem_ready` still low, the access is aborted at that edge:
    - `mem_req` drops;
    - the owner's rdata register is loaded with 0, for both fetch and load;
    - the owner's ack pulses next cycle;
    - `err` sets and clears only on reset;
    - the FSM returns to IDLE.
- `stall = (dm_req & ~dm_ack) | (if_req & ~if_ack)`.
- `mem_ready` is ignored in IDLE.
- The arbiter does not check `dm_op` or the addresses while in a WAIT state.

## Timing
- Reset values (asynchronous, immediate): state IDLE, counter 0, and every registered output 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata`, `if_ack`, `dm_ack`, `err`).
- Reset mid-access drops `mem_req` at once, and no ack is issued.
- Latency:
  - Request seen in cycle 0 → `mem_req` high in cycle 1.
  - `mem_ready` high in cycle 1 → ack and rdata valid in cycle 2.
  - Each extra wait cycle of `mem_ready` adds one cycle.
- Throughput with `mem_ready` always high:
  - Alternating ports: one access per 2 cycles, because the ack cycle is IDLE and grants the other port.
  - Same port back-to-back: one access per 3 cycles.
- Simultaneous `if_req` and `dm_req` in IDLE: DM is granted; IF waits, and `stall` stays high.
- Timeout abort happens at the end of the `TIMEOUT`-th WAIT cycle; the ack follows one cycle later.

## Test plan
- Load with `mem_ready` high from cycle 1 (`dm_op=14`, addr `0x40`, `mem_rdata=0x1234_5678`): `mem_req=1`/`mem_we=0` in cycle 1; `dm_ack=1` and `dm_rdata=0x12345678` in cycle 2; `stall` high in cycles 0–1 and low in cycle 2.
- Store (`dm_op=13`, `dm_wdata=0xCAFEF00D`): `mem_we=1` and `mem_wdata=0xCAFEF00D` while `mem_req` is high; `dm_ack` pulses once; `dm_rdata` keeps its prior value.
- `if_req` and `dm_req` both raised in cycle 0, `mem_ready` always high: DM is granted in cycle 1 with `dm_ack` in cycle 2; IF is granted in cycle 3 with `if_ack` in cycle 4.
- Fetch with `mem_ready` delayed 3 cycles: `mem_req` and `mem_addr` stay stable for 4 cycles, then `if_ack` pulses once; `if_req` held in the ack cycle is not regranted.
- `mem_ready` tied low, `TIMEOUT=16`: `mem_req` is high for 16 cycles and then drops; `dm_ack` pulses with `dm_rdata=0`; `err=1` and stays set through later successful accesses.
- `rst_n` asserted in the middle of a WAIT: `mem_req`, acks and `err` go to 0 immediately; after release the FSM is IDLE and regrants the still-held request.
